sram_like_arbiter: RTL and testbench



---
 rtl/sram_like_arbiter_if.sv | 33 +++
 rtl/sram_like_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_arbiter_if.sv
// One SRAM-like channel: address phase (req/addr_ok) and in-order response phase (data_ok/rdata).
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req,
        output wr,
        output size,
        output addr,
        output wdata,
        input  addr_ok,
        input  data_ok,
        input  rdata
    );

    modport slave (
        input  req,
        input  wr,
        input  size,
        input  addr,
        input  wdata,
        output addr_ok,
        output data_ok,
        output rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between the instruction and data masters; an in-order tag
// FIFO routes responses back. Define ARB_ROUND_ROBIN_EN for round-robin, else data has fixed priority.
module sram_like_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_like_arbiter_if.slave   inst_bus,
    sram_like_arbiter_if.slave   data_bus,
    sram_like_arbiter_if.master  mem_bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    logic [DEPTH-1:0] tag_q, tag_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             locked_q, locked_d;
    logic             lock_id_q, lock_id_d;
    logic             rr_last_q, rr_last_d;

    logic             grant_s;
    logic             full_s;
    logic             empty_s;
    logic             sel_req_s;
    logic             sel_wr_s;
    logic [1:0]       sel_size_s;
    logic [31:0]      sel_addr_s;
    logic [31:0]      sel_wdata_s;
    logic             mem_req_s;
    logic             accept_s;
    logic             pop_s;
    logic             head_id_s;

    assign full_s  = (count_q == CNT_FULL);
    assign empty_s = (count_q == {CW{1'b0}});

    // Grant selection: a stalled address owns the port until it is accepted
    always_comb begin
        grant_s = ID_INST;
        if (locked_q) begin
            grant_s = lock_id_q;
        end else if (inst_bus.req && !data_bus.req) begin
            grant_s = ID_INST;
        end else if (!inst_bus.req && data_bus.req) begin
            grant_s = ID_DATA;
        end else if (inst_bus.req && data_bus.req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_s = ~rr_last_q;
`else
            grant_s = ID_DATA;
`endif
        end else begin
            grant_s = ID_INST;
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic rr_last_unused_s;
    assign rr_last_unused_s = rr_last_q;
`endif

    // Address-phase mux from the granted master; inst fields when nothing is granted
    always_comb begin
        sel_req_s   = inst_bus.req;
        sel_wr_s    = inst_bus.wr;
        sel_size_s  = inst_bus.size;
        sel_addr_s  = inst_bus.addr;
        sel_wdata_s = inst_bus.wdata;
        if (grant_s == ID_DATA) begin
            sel_req_s   = data_bus.req;
            sel_wr_s    = data_bus.wr;
            sel_size_s  = data_bus.size;
            sel_addr_s  = data_bus.addr;
            sel_wdata_s = data_bus.wdata;
        end else begin
            sel_req_s   = inst_bus.req;
            sel_wr_s    = inst_bus.wr;
            sel_size_s  = inst_bus.size;
            sel_addr_s  = inst_bus.addr;
            sel_wdata_s = inst_bus.wdata;
        end
    end

    // Full blocks requests even when a pop is in flight, so data_ok never feeds addr_ok
    assign mem_req_s = sel_req_s & ~full_s;
    assign accept_s  = mem_req_s & mem_bus.addr_ok;
    assign pop_s     = mem_bus.data_ok & ~empty_s;
    assign head_id_s = tag_q[rd_ptr_q];

    assign mem_bus.req   = mem_req_s;
    assign mem_bus.wr    = sel_wr_s;
    assign mem_bus.size  = sel_size_s;
    assign mem_bus.addr  = sel_addr_s;
    assign mem_bus.wdata = sel_wdata_s;

    assign inst_bus.addr_ok = accept_s & (grant_s == ID_INST);
    assign data_bus.addr_ok = accept_s & (grant_s == ID_DATA);
    assign inst_bus.data_ok = pop_s & (head_id_s == ID_INST);
    assign data_bus.data_ok = pop_s & (head_id_s == ID_DATA);
    assign inst_bus.rdata   = mem_bus.rdata;
    assign data_bus.rdata   = mem_bus.rdata;

    // Next-state for tag FIFO, lock and round-robin history
    always_comb begin
        tag_d     = tag_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        locked_d  = locked_q;
        lock_id_d = lock_id_q;
        rr_last_d = rr_last_q;

        if (accept_s) begin
            tag_d[wr_ptr_q] = grant_s;
            wr_ptr_d        = wr_ptr_q + PW'(1);
            rr_last_d       = grant_s;
            locked_d        = 1'b0;
        end else if (mem_req_s) begin
            locked_d  = 1'b1;
            lock_id_d = grant_s;
        end else begin
            locked_d  = locked_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({accept_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset; outstanding tags are discarded on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q     <= {DEPTH{1'b0}};
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            count_q   <= {CW{1'b0}};
            locked_q  <= 1'b0;
            lock_id_q <= 1'b0;
            rr_last_q <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            locked_q  <= locked_d;
            lock_id_q <= lock_id_d;
            rr_last_q <= rr_last_d;
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed vector table plus randomized traffic vs a queue model.
module tb_sram_like_arbiter;
    localparam int DEPTH = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit          r;
        bit          ir;
        bit          iw;
        logic [1:0]  isz;
        logic [31:0] ia;
        logic [31:0] iwd;
        bit          dr;
        bit          dw;
        logic [1:0]  dsz;
        logic [31:0] da;
        logic [31:0] dwd;
        bit          mao;
        bit          mdo;
        logic [31:0] mrd;
        bit          er;
        logic [31:0] ea;
        logic [3:0]  eok;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_like_arbiter_if inst_bus();
    sram_like_arbiter_if data_bus();
    sram_like_arbiter_if mem_bus();

    sram_like_arbiter #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .inst_bus (inst_bus),
        .data_bus (data_bus),
        .mem_bus  (mem_bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model: queue of outstanding source ids, stalled owner, last accepted source
    bit mq[$];
    int stall = -1;
    bit last  = 1'b0;
    bit m_acc, m_g, m_pop, m_req;

    localparam logic [31:0] IA = 32'hBFC0_0000;
    localparam logic [31:0] IB = 32'hBFC0_0004;
    localparam logic [31:0] DA = 32'h8000_1000;
    localparam logic [31:0] DB = 32'h8000_2000;

    function automatic vec_t mk(bit r, bit ir, logic [31:0] ia, bit dr, bit dw, logic [31:0] da,
                                logic [31:0] dwd, bit mao, bit mdo, logic [31:0] mrd,
                                bit er, logic [31:0] ea, logic [3:0] eok);
        vec_t v;
        v.r = r; v.ir = ir; v.iw = 1'b0; v.isz = 2'd2; v.ia = ia; v.iwd = 32'h0;
        v.dr = dr; v.dw = dw; v.dsz = 2'd2; v.da = da; v.dwd = dwd;
        v.mao = mao; v.mdo = mdo; v.mrd = mrd;
        v.er = er; v.ea = ea; v.eok = eok;
        return v;
    endfunction

    task automatic model_eval(output logic [135:0] e);
        bit g, sreq, swr, acc, pop, hd;
        logic [1:0]  ssz;
        logic [31:0] sa, sw;
        if (stall >= 0)                          g = (stall == 1);
        else if (inst_bus.req && !data_bus.req)  g = 1'b0;
        else if (data_bus.req && !inst_bus.req)  g = 1'b1;
        else if (inst_bus.req && data_bus.req)   g = RR ? !last : 1'b1;
        else                                     g = 1'b0;
        if (g) begin
            swr = data_bus.wr; ssz = data_bus.size; sa = data_bus.addr; sw = data_bus.wdata;
        end else begin
            swr = inst_bus.wr; ssz = inst_bus.size; sa = inst_bus.addr; sw = inst_bus.wdata;
        end
        sreq = (g ? data_bus.req : inst_bus.req) && (mq.size() < DEPTH);
        acc  = sreq && mem_bus.addr_ok;
        pop  = mem_bus.data_ok && (mq.size() > 0);
        hd   = pop ? mq[0] : 1'b0;
        e = {sreq, swr, ssz, sa, sw, acc && !g, acc && g, pop && !hd, pop && hd,
             mem_bus.rdata, mem_bus.rdata};
        m_acc = acc; m_g = g; m_pop = pop; m_req = sreq;
    endtask

    task automatic model_commit();
        if (rst) begin
            mq.delete();
            stall = -1;
            last  = 1'b0;
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_acc) begin
                mq.push_back(m_g);
                last  = m_g;
                stall = -1;
            end else if (m_req) begin
                stall = m_g ? 1 : 0;
            end
        end
    endtask

    task automatic apply(input vec_t v);
        rst            = v.r;
        inst_bus.req   = v.ir;  inst_bus.wr = v.iw;  inst_bus.size = v.isz;
        inst_bus.addr  = v.ia;  inst_bus.wdata = v.iwd;
        data_bus.req   = v.dr;  data_bus.wr = v.dw;  data_bus.size = v.dsz;
        data_bus.addr  = v.da;  data_bus.wdata = v.dwd;
        mem_bus.addr_ok = v.mao; mem_bus.data_ok = v.mdo; mem_bus.rdata = v.mrd;
    endtask

    task automatic step(input vec_t v, input bit use_tab, input int idx);
        logic [135:0] e, a;
        logic [100:0] ta, te;
        @(negedge clk);
        apply(v);
        #1;
        model_eval(e);
        a = {mem_bus.req, mem_bus.wr, mem_bus.size, mem_bus.addr, mem_bus.wdata,
             inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok,
             inst_bus.rdata, data_bus.rdata};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL model step=%0d actual=%h expected=%h", idx, a, e);
        end
        if (use_tab) begin
            ta = {mem_bus.req, mem_bus.addr, inst_bus.addr_ok, data_bus.addr_ok,
                  inst_bus.data_ok, data_bus.data_ok, inst_bus.rdata, data_bus.rdata};
            te = {v.er, v.ea, v.eok, v.mrd, v.mrd};
            total++;
            if (ta !== te) begin
                bad++;
                $display("FAIL vector%0d actual=%h expected=%h", idx, ta, te);
            end
        end
        model_commit();
    endtask

    vec_t tab[$];

    initial begin
        vec_t v;
        bit ip, dp;
        vec_t iv, dv;

        // rst  ireq ia  dreq dwr da  dwd  aok dok rdata  exp: mreq maddr ok{ia,da,id,dd}
        tab.push_back(mk(1, 0, 0,  0, 0, 0,  0, 0, 0, 0,            0, 0,  4'b0000));
        tab.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0, 0, 0,            0, 0,  4'b0000));
        // single inst read
        tab.push_back(mk(0, 1, IA, 0, 0, 0,  0, 1, 0, 0,            1, IA, 4'b1000));
        tab.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0, 1, 32'h3C1D0000, 0, 0,  4'b0010));
        // simultaneous requests
        tab.push_back(mk(0, 1, IA, 1, 1, DA, 32'h11223344, 1, 0, 0, 1, DA, 4'b0100));
        tab.push_back(mk(0, 1, IA, 1, 1, DB, 32'h55667788, 1, 0, 0, 1, RR ? IA : DB,
                         RR ? 4'b1000 : 4'b0100));
        tab.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0, 1, 32'hAA,       0, 0,  4'b0001));
        tab.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0, 1, 32'hBB,       0, 0,
                         RR ? 4'b0010 : 4'b0001));
        // address held through a stall, no switch to data
        tab.push_back(mk(0, 1, IB, 0, 0, 0,  0, 0, 0, 0,            1, IB, 4'b0000));
        tab.push_back(mk(0, 1, IB, 1, 0, DA, 0, 0, 0, 0,            1, IB, 4'b0000));
        tab.push_back(mk(0, 1, IB, 1, 0, DA, 0, 0, 0, 0,            1, IB, 4'b0000));
        tab.push_back(mk(0, 1, IB, 1, 0, DA, 0, 1, 0, 0,            1, IB, 4'b1000));
        tab.push_back(mk(0, 0, 0,  1, 0, DA, 0, 1, 0, 0,            1, DA, 4'b0100));
        tab.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0, 1, 32'h10,       0, 0,  4'b0010));
        tab.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0, 1, 32'h20,       0, 0,  4'b0001));
        // interleaved inst, data, inst responses
        tab.push_back(mk(0, 1, IA, 0, 0, 0,  0, 1, 0, 0,            1, IA, 4'b1000));
        tab.push_back(mk(0, 0, 0,  1, 0, DA, 0, 1, 0, 0,            1, DA, 4'b0100));
        tab.push_back(mk(0, 1, IB, 0, 0, 0,  0, 1, 0, 0,            1, IB, 4'b1000));
        tab.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0, 1, 32'd1,        0, 0,  4'b0010));
        tab.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0, 1, 32'd2,        0, 0,  4'b0001));
        tab.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0, 1, 32'd3,        0, 0,  4'b0010));
        // fill to DEPTH, full blocks even with a pop, resume next cycle
        for (int i = 0; i < DEPTH; i++)
            tab.push_back(mk(0, 0, 0, 1, 0, DA, 0, 1, 0, 0,         1, DA, 4'b0100));
        tab.push_back(mk(0, 0, 0,  1, 0, DA, 0, 1, 0, 0,            0, DA, 4'b0000));
        tab.push_back(mk(0, 0, 0,  1, 0, DA, 0, 1, 1, 32'd5,        0, DA, 4'b0001));
        tab.push_back(mk(0, 0, 0,  1, 0, DA, 0, 1, 0, 0,            1, DA, 4'b0100));
        // reset with tags outstanding, then a stray response
        tab.push_back(mk(1, 0, 0,  0, 0, 0,  0, 0, 0, 0,            0, 0,  4'b0000));
        tab.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0, 1, 32'd7,        0, 0,  4'b0000));
        tab.push_back(mk(0, 1, IA, 0, 0, 0,  0, 1, 0, 0,            1, IA, 4'b1000));
        tab.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0, 1, 32'd9,        0, 0,  4'b0010));

        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        for (int i = 0; i < tab.size(); i++) step(tab[i], 1'b1, i);

        // randomized traffic: masters hold requests until accepted
        ip = 1'b0; dp = 1'b0;
        iv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        dv = iv;
        for (int n = 0; n < 3000; n++) begin
            if (!ip && $urandom_range(2) == 0) begin
                ip = 1'b1; iv.iw = 1'($urandom_range(1)); iv.isz = 2'($urandom_range(2));
                iv.ia = $urandom; iv.iwd = $urandom;
            end
            if (!dp && $urandom_range(2) == 0) begin
                dp = 1'b1; dv.dw = 1'($urandom_range(1)); dv.dsz = 2'($urandom_range(2));
                dv.da = $urandom; dv.dwd = $urandom;
            end
            v = iv;
            v.r   = ($urandom_range(199) == 0);
            v.ir  = ip;
            v.dr  = dp; v.dw = dv.dw; v.dsz = dv.dsz; v.da = dv.da; v.dwd = dv.dwd;
            v.mao = ($urandom_range(3) != 0);
            v.mdo = ($urandom_range(2) == 0);
            v.mrd = $urandom;
            step(v, 1'b0, 1000 + n);
            if (m_acc && !m_g) ip = 1'b0;
            if (m_acc && m_g)  dp = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
